// File: rtl/rk86_sd_spi_pkg.sv
// Shared definitions for the RK86 SD-card SPI byte engine.
// Optional feature macro: SD_AUTO_READ_EN (see rk86_sd_spi.sv).
package rk86_sd_pkg;

    // Register select values on I_ADDR
    localparam logic REG_CTRL = 1'b0;
    localparam logic REG_DATA = 1'b1;

    // Bit positions in the control / status register
    localparam int unsigned CTRL_CS   = 0;
    localparam int unsigned CTRL_FAST = 1;
    localparam int unsigned STAT_BUSY = 7;

    // MOSI level driven whenever no byte is being shifted
    localparam logic IDLE_MOSI = 1'b1;

    typedef enum logic {
        IDLE,
        SHIFT
    } sd_state_e;

    // Builds the reg0 read value {busy,5'b0,fast,cs}
    function automatic logic [7:0] status_byte(input logic busy, input logic fast,
                                               input logic cs);
        logic [7:0] s;
        s            = '0;
        s[STAT_BUSY] = busy;
        s[CTRL_FAST] = fast;
        s[CTRL_CS]   = cs;
        return s;
    endfunction

endpackage

// File: rtl/rk86_sd_spi_if.sv
// CPU-side bus of the SD SPI engine: register select, data, strobes, read data and busy.
interface rk86_sd_spi_if;
    logic       I_ADDR;
    logic [7:0] I_DATA;
    logic       I_WE_N;
    logic       I_RD_N;
    logic [7:0] O_DATA;
    logic       O_BUSY;

    modport master (
        output I_ADDR, I_DATA, I_WE_N, I_RD_N,
        input  O_DATA, O_BUSY
    );

    modport slave (
        input  I_ADDR, I_DATA, I_WE_N, I_RD_N,
        output O_DATA, O_BUSY
    );
endinterface

// File: rtl/rk86_sd_shifter.sv
// SPI mode-0 byte shifter: clock divider, half-period counter, SCLK generation and
// tx/rx shift registers. A one-cycle start_i in IDLE launches a byte; busy_o drops when done.
module rk86_sd_shifter
    import rk86_sd_pkg::*;
#(
    parameter int unsigned DIV_SLOW = 63,
    parameter int unsigned DIV_FAST = 2
) (
    input  logic       CLK,
    input  logic       N_RESET,
    input  logic       start_i,
    input  logic [7:0] tx_i,
    input  logic       fast_i,
    input  logic       miso_i,
    output logic       busy_o,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic [7:0] rx_o
);

    localparam int unsigned DivMax = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int unsigned DivW   = $clog2(DivMax + 1);
    localparam logic [DivW-1:0] DivSlowV = DivW'(DIV_SLOW);
    localparam logic [DivW-1:0] DivFastV = DivW'(DIV_FAST);
    localparam logic [DivW-1:0] OneV     = DivW'(1);

    sd_state_e       state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [DivW-1:0] cnt_q, cnt_d;
    logic [3:0]      half_q, half_d;
    logic            sclk_q, sclk_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic [7:0]      rx_q, rx_d;
    logic            half_end;

    assign half_end = (cnt_q == div_q - OneV);

    // State register; reset abandons any byte in flight and parks SCLK low
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            half_q  <= '0;
            sclk_q  <= 1'b0;
            tx_q    <= '0;
            rx_sh_q <= '0;
            rx_q    <= 8'hFF;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            sclk_q  <= sclk_d;
            tx_q    <= tx_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
        end
    end

    // Next-state: divider latched at start, 16 half-periods, sample on rise, shift on fall
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        sclk_d  = sclk_q;
        tx_d    = tx_q;
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SHIFT;
                    div_d   = fast_i ? DivFastV : DivSlowV;
                    cnt_d   = '0;
                    half_d  = '0;
                    sclk_d  = 1'b0;
                    tx_d    = tx_i;
                end
            end
            SHIFT: begin
                if (half_end) begin
                    cnt_d  = '0;
                    half_d = half_q + 4'd1;
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        rx_sh_d = {rx_sh_q[6:0], miso_i};
                    end else begin
                        sclk_d = 1'b0;
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                    // Last half-period always ends on a falling edge, so rx_sh is complete
                    if (half_q == 4'd15) begin
                        state_d = IDLE;
                        sclk_d  = 1'b0;
                        rx_d    = rx_sh_q;
                    end
                end else begin
                    cnt_d = cnt_q + OneV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q == SHIFT);
    assign sclk_o = sclk_q;
    assign mosi_o = (state_q == SHIFT) ? tx_q[7] : IDLE_MOSI;
    assign rx_o   = rx_q;

endmodule

// File: rtl/rk86_sd_spi.sv
// RK86 SD-card SPI engine top: two CPU registers (ctrl/status, data), strobe edge detect,
// MISO synchroniser and read-data mux around the byte shifter.
// Build option: define SD_AUTO_READ_EN to make a reg1 read edge in IDLE launch an 8'hFF byte.
module rk86_sd_spi
    import rk86_sd_pkg::*;
#(
    parameter int unsigned DIV_SLOW = 63,
    parameter int unsigned DIV_FAST = 2
) (
    input  logic          CLK,
    input  logic          N_RESET,
    rk86_sd_spi_if.slave  bus,
    output logic          SD_NCS,
    output logic          SD_CLK,
    output logic          SD_MOSI,
    input  logic          SD_MISO
);

    logic       we_n_q, rd_n_q;
    logic       cs_q, cs_d;
    logic       fast_q, fast_d;
    logic       miso_meta_q, miso_sync_q;
    logic       we_fire, rd_fire;
    logic       start;
    logic [7:0] start_tx;
    logic       busy;
    logic [7:0] rx;

    // Strobes are level and long; act only on the first cycle they are seen low
    assign we_fire = we_n_q & ~bus.I_WE_N;
    assign rd_fire = rd_n_q & ~bus.I_RD_N;

    // Strobe history, control bits and MISO two-flop synchroniser
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            we_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            cs_q        <= 1'b0;
            fast_q      <= 1'b0;
            miso_meta_q <= 1'b1;
            miso_sync_q <= 1'b1;
        end else begin
            we_n_q      <= bus.I_WE_N;
            rd_n_q      <= bus.I_RD_N;
            cs_q        <= cs_d;
            fast_q      <= fast_d;
            miso_meta_q <= SD_MISO;
            miso_sync_q <= miso_meta_q;
        end
    end

    // Register writes and byte launch; data writes while busy are dropped
    always_comb begin
        cs_d     = cs_q;
        fast_d   = fast_q;
        start    = 1'b0;
        start_tx = bus.I_DATA;
        if (we_fire) begin
            if (bus.I_ADDR == REG_CTRL) begin
                cs_d   = bus.I_DATA[CTRL_CS];
                fast_d = bus.I_DATA[CTRL_FAST];
            end else if (!busy) begin
                start = 1'b1;
            end
        end
`ifdef SD_AUTO_READ_EN
        if (rd_fire && (bus.I_ADDR == REG_DATA) && !busy) begin
            start    = 1'b1;
            start_tx = 8'hFF;
        end
`endif
    end

`ifndef SD_AUTO_READ_EN
    // Reads have no side effects in this build
    logic unused_rd_fire;
    assign unused_rd_fire = rd_fire;
`endif

    rk86_sd_shifter #(
        .DIV_SLOW (DIV_SLOW),
        .DIV_FAST (DIV_FAST)
    ) u_shifter (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .start_i (start),
        .tx_i    (start_tx),
        .fast_i  (fast_q),
        .miso_i  (miso_sync_q),
        .busy_o  (busy),
        .sclk_o  (SD_CLK),
        .mosi_o  (SD_MOSI),
        .rx_o    (rx)
    );

    assign SD_NCS     = ~cs_q;
    assign bus.O_BUSY = busy;
    assign bus.O_DATA = (bus.I_ADDR == REG_CTRL) ? status_byte(busy, fast_q, cs_q) : rx;

endmodule

// File: tb/tb_rk86_sd_spi.sv
// Self-checking bench for rk86_sd_spi: reset, slow/fast bytes with a card model,
// write-while-busy, long strobe, a vector table and randomized transfers.
module tb_rk86_sd_spi;

    logic CLK = 1'b0;
    logic N_RESET;
    logic SD_NCS, SD_CLK, SD_MOSI;
    logic SD_MISO;

    rk86_sd_spi_if bus ();

    rk86_sd_spi dut (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .bus     (bus),
        .SD_NCS  (SD_NCS),
        .SD_CLK  (SD_CLK),
        .SD_MOSI (SD_MOSI),
        .SD_MISO (SD_MISO)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Card model: capture MOSI on rising SCLK, optionally shift out card_sh on falling SCLK
    logic [7:0] mosi_sh;
    int         rise_cnt;
    logic       echo_en;
    logic [7:0] card_sh;

    always @(posedge SD_CLK) begin
        mosi_sh  = {mosi_sh[6:0], SD_MOSI};
        rise_cnt = rise_cnt + 1;
    end

    always @(negedge SD_CLK) begin
        if (echo_en) begin
            card_sh = {card_sh[6:0], 1'b0};
            SD_MISO = card_sh[7];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected busy length from the divider rule
    function automatic int exp_len(input logic fast);
        return 16 * (fast ? 2 : 63);
    endfunction

    // O_DATA is a combinational mux, so registers are read without a strobe
    task automatic read_reg(input logic a, output logic [7:0] d);
        @(negedge CLK);
        bus.I_ADDR = a;
        @(negedge CLK);
        d = bus.O_DATA;
    endtask

    task automatic write_reg0(input logic [7:0] d);
        @(negedge CLK);
        bus.I_ADDR = 1'b0;
        bus.I_DATA = d;
        bus.I_WE_N = 1'b0;
        repeat (3) @(negedge CLK);
        bus.I_WE_N = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    // Writes reg1, optionally a second reg1 write at w2_at, reads reg0 mid-way; measures busy
    task automatic xfer(input logic [7:0] tx, input int hold, input int w2_at,
                        input logic [7:0] w2, output int blen, output logic [7:0] stat_mid,
                        output int timeout);
        int   cyc;
        logic seen, done;
        blen = 0; stat_mid = '0; timeout = 0; seen = 0; done = 0; cyc = 0;
        @(negedge CLK);
        mosi_sh    = '0;
        rise_cnt   = 0;
        bus.I_ADDR = 1'b1;
        bus.I_DATA = tx;
        bus.I_WE_N = 1'b0;
        while (!done) begin
            @(negedge CLK);
            cyc++;
            if (cyc == hold) bus.I_WE_N = 1'b1;
            if (w2_at > 0 && cyc == w2_at) begin
                bus.I_ADDR = 1'b1;
                bus.I_DATA = w2;
                bus.I_WE_N = 1'b0;
            end
            if (w2_at > 0 && cyc == w2_at + 2) bus.I_WE_N = 1'b1;
            if (bus.O_BUSY) begin
                blen++;
                seen = 1'b1;
            end
            if (cyc == hold + 3) bus.I_ADDR = 1'b0;
            if (cyc == hold + 4) begin
                stat_mid   = bus.O_DATA;
                bus.I_ADDR = 1'b1;
            end
            if (seen && !bus.O_BUSY && cyc > hold + 5 && cyc > w2_at + 3) done = 1'b1;
            if (cyc > 3000) begin
                timeout = 1;
                done    = 1'b1;
            end
        end
    endtask

    typedef struct {
        logic [7:0] ctrl;
        logic [7:0] tx;
        logic       miso;
        int         len;
        logic [7:0] rx;
        logic [7:0] stat;
    } vec_t;

    vec_t       vecs [4];
    int         blen, tmo;
    logic [7:0] stat, d, last_rx;

    initial begin
        vecs[0] = '{ctrl: 8'h03, tx: 8'h51, miso: 1'b0, len: 32,   rx: 8'h00, stat: 8'h83};
        vecs[1] = '{ctrl: 8'h02, tx: 8'hC3, miso: 1'b1, len: 32,   rx: 8'hFF, stat: 8'h82};
        vecs[2] = '{ctrl: 8'h01, tx: 8'h0F, miso: 1'b1, len: 1008, rx: 8'hFF, stat: 8'h81};
        vecs[3] = '{ctrl: 8'h00, tx: 8'h80, miso: 1'b0, len: 1008, rx: 8'h00, stat: 8'h80};

        N_RESET = 1'b0;
        bus.I_ADDR = 1'b0; bus.I_DATA = '0; bus.I_WE_N = 1'b1; bus.I_RD_N = 1'b1;
        SD_MISO = 1'b1; echo_en = 1'b0; card_sh = '0; mosi_sh = '0; rise_cnt = 0;
        repeat (3) @(negedge CLK);
        check("rst_ncs", SD_NCS, 1);
        check("rst_clk", SD_CLK, 0);
        check("rst_mosi", SD_MOSI, 1);
        check("rst_busy", bus.O_BUSY, 0);
        N_RESET = 1'b1;
        read_reg(1'b1, d); check("rst_rx", d, 8'hFF);
        read_reg(1'b0, d); check("rst_stat", d, 8'h00);

        // Reset abandons a slow byte at half-period 7
        write_reg0(8'h01);
        check("cs_on_ncs", SD_NCS, 0);
        SD_MISO = 1'b0;
        @(negedge CLK);
        bus.I_ADDR = 1'b1; bus.I_DATA = 8'hA5; bus.I_WE_N = 1'b0;
        repeat (2) @(negedge CLK);
        bus.I_WE_N = 1'b1;
        repeat (470) @(negedge CLK);
        check("mid_busy", bus.O_BUSY, 1);
        N_RESET = 1'b0;
        #1;
        check("arst_ncs", SD_NCS, 1);
        check("arst_clk", SD_CLK, 0);
        check("arst_mosi", SD_MOSI, 1);
        check("arst_busy", bus.O_BUSY, 0);
        @(negedge CLK);
        N_RESET = 1'b1;
        read_reg(1'b1, d); check("arst_rx", d, 8'hFF);
        read_reg(1'b0, d); check("arst_stat", d, 8'h00);
        repeat (5) @(negedge CLK);
        check("arst_idle", bus.O_BUSY, 0);

        // Slow byte with the card echoing 8'h3C
        write_reg0(8'h01);
        card_sh = 8'h3C; SD_MISO = card_sh[7]; echo_en = 1'b1;
        xfer(8'hA5, 3, 0, 8'h00, blen, stat, tmo);
        echo_en = 1'b0;
        check("slow_tmo", tmo, 0);
        check("slow_len", blen, 1008);
        check("slow_mosi", mosi_sh, 8'hA5);
        check("slow_edges", rise_cnt, 8);
        check("slow_stat", stat, 8'h81);
        check("slow_idle_mosi", SD_MOSI, 1);
        read_reg(1'b1, d); check("slow_rx", d, 8'h3C);

        // Fast byte with a second write while busy: ignored
        write_reg0(8'h03);
        SD_MISO = 1'b1;
        xfer(8'hA5, 2, 12, 8'h00, blen, stat, tmo);
        check("wbusy_tmo", tmo, 0);
        check("wbusy_len", blen, 32);
        check("wbusy_mosi", mosi_sh, 8'hA5);
        check("wbusy_edges", rise_cnt, 8);
        check("wbusy_stat", stat, 8'h83);

        // Strobe held 100 CLKs: exactly one byte
        xfer(8'h3C, 100, 0, 8'h00, blen, stat, tmo);
        check("long_tmo", tmo, 0);
        check("long_len", blen, 32);
        check("long_edges", rise_cnt, 8);
        check("long_mosi", mosi_sh, 8'h3C);
        check("long_stat", stat, 8'h03);

        // Vector table
        for (int i = 0; i < 4; i++) begin
            write_reg0(vecs[i].ctrl);
            SD_MISO = vecs[i].miso;
            xfer(vecs[i].tx, 3, 0, 8'h00, blen, stat, tmo);
            check("vec_tmo", tmo, 0);
            check("vec_len", blen, vecs[i].len);
            check("vec_mosi", mosi_sh, vecs[i].tx);
            check("vec_stat", stat, vecs[i].stat);
            read_reg(1'b1, d); check("vec_rx", d, vecs[i].rx);
        end

        // Randomized transfers against the rule-level model
        for (int i = 0; i < 10; i++) begin
            logic       f, c, m;
            logic [7:0] t;
            f = ($urandom_range(0, 3) != 0);
            c = $urandom_range(0, 1);
            m = $urandom_range(0, 1);
            t = 8'($urandom);
            write_reg0({6'b0, f, c});
            check("rnd_ncs", SD_NCS, !c);
            SD_MISO = m;
            xfer(t, 2, 0, 8'h00, blen, stat, tmo);
            check("rnd_tmo", tmo, 0);
            check("rnd_len", blen, exp_len(f));
            check("rnd_mosi", mosi_sh, t);
            check("rnd_edges", rise_cnt, 8);
            check("rnd_stat_busy", stat, {1'b1, 5'b0, f, c});
            read_reg(1'b1, d); check("rnd_rx", d, m ? 8'hFF : 8'h00);
            read_reg(1'b0, d); check("rnd_stat_idle", d, {1'b0, 5'b0, f, c});
            last_rx = m ? 8'hFF : 8'h00;
        end

`ifdef SD_AUTO_READ_EN
        // Read edge in IDLE returns old rx and sends 8'hFF
        begin
            int cyc;
            write_reg0(8'h03);
            SD_MISO = 1'b0;
            @(negedge CLK);
            mosi_sh = '0; rise_cnt = 0;
            bus.I_ADDR = 1'b1; bus.I_RD_N = 1'b0;
            @(negedge CLK);
            check("auto_old_rx", bus.O_DATA, last_rx);
            check("auto_busy", bus.O_BUSY, 1);
            repeat (3) @(negedge CLK);
            bus.I_RD_N = 1'b1;
            cyc = 0;
            while (bus.O_BUSY && cyc < 200) begin
                @(negedge CLK);
                cyc++;
            end
            check("auto_done", bus.O_BUSY, 0);
            check("auto_mosi", mosi_sh, 8'hFF);
            check("auto_edges", rise_cnt, 8);
            read_reg(1'b1, d); check("auto_rx", d, 8'h00);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
